// File: rtl/tnet_pkg.sv
// tNet packet definitions shared by the ring transmitter and receiver.
// Contents:
//   - header bit positions of the 128-bit tNet packet
//   - DST_BCAST    broadcast destination address
//   - tnet_pkt_t   packed packet layout, MSB first
//   - tnet_tx_st_t transmitter FSM states
package tnet_pkg;

  localparam int OP_HI  = 127;
  localparam int OP_LO  = 120;
  localparam int SYNC_B = 119;
  localparam int SEQ_HI = 118;
  localparam int SEQ_LO = 114;
  localparam int DST_HI = 113;
  localparam int DST_LO = 105;
  localparam int SRC_HI = 104;
  localparam int SRC_LO = 96;

  localparam logic [8:0] DST_BCAST = 9'h1FF;

  typedef struct packed {
    logic [7:0]  op;
    logic        sync;
    logic [4:0]  seq;
    logic [8:0]  dst;
    logic [8:0]  src;
    logic [95:0] dt;
  } tnet_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_SEND      = 2'd2
  } tnet_tx_st_t;

endpackage

// File: rtl/tnet_pkt_tx_if.sv
// Command and Aurora TX AXI-Stream bundle of the tNet transmitter.
//   cmd_*        command handshake from the command processor
//   m_axi_tx_*   128-bit packet stream towards the Aurora core
// Modports:
//   master  transmitter side (accepts commands, drives the TX stream)
//   slave   environment side (issues commands, sinks the TX stream)
interface tnet_pkt_tx_if;

  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_op;
  logic         cmd_sync;
  logic [8:0]   cmd_dst;
  logic [95:0]  cmd_dt;

  logic [127:0] m_axi_tx_tdata;
  logic         m_axi_tx_tvalid;
  logic         m_axi_tx_tready;

  modport master (
    input  cmd_valid, cmd_op, cmd_sync, cmd_dst, cmd_dt, m_axi_tx_tready,
    output cmd_ready, m_axi_tx_tdata, m_axi_tx_tvalid
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_sync, cmd_dst, cmd_dt, m_axi_tx_tready,
    input  cmd_ready, m_axi_tx_tdata, m_axi_tx_tvalid
  );

endinterface

// File: rtl/tnet_sync_fifo.sv
// Single-clock FIFO with flush, used as the transmitter command queue.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers only)
//   push, din    write when not full
//   pop, dout    dout shows the head entry; pop advances when not empty
//   flush        discards all entries (takes priority over push/pop)
//   full, empty  status; count = number of stored entries (0..2**AW)
module tnet_sync_fifo #(
  parameter int W  = 128,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW + 1)'(1);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == DEPTH_C);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tnet_pkt_tx.sv
// tNet ring originating transmitter.
// Formats local commands into 128-bit tNet packets, queues them and drives
// the Aurora TX AXI-Stream. Sync packets wait for the next time-slot tick,
// plain packets leave as soon as the output stage is free.
// Ports:
//   user_clock, user_aresetn  Aurora user clock, asynchronous active-low reset
//   ID          own node ID, placed in the src field
//   channel_up  Aurora link up; link loss discards everything queued
//   sync_tick   one-cycle time-slot pulse
//   bus         command handshake + TX stream (tnet_pkt_tx_if.master)
//   tx_cnt      packets sent (wraps)
//   drop_cnt    packets discarded on link loss (saturates)
//   busy        a packet is held or the queue is non-empty
module tnet_pkt_tx
  import tnet_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic                user_clock,
  input  logic                user_aresetn,
  input  logic [7:0]          ID,
  input  logic                channel_up,
  input  logic                sync_tick,
  tnet_pkt_tx_if.master       bus,
  output logic [31:0]         tx_cnt,
  output logic [15:0]         drop_cnt,
  output logic                busy
);

  tnet_tx_st_t        state, state_nxt;
  logic [127:0]       tdata;
  logic               tvalid, tvalid_nxt;
  logic [4:0]         seq;
  tnet_pkt_t          cmd_pkt;

  logic               fifo_push, fifo_pop, fifo_flush;
  logic               fifo_full, fifo_empty;
  logic [127:0]       fifo_head;
  logic [FIFO_AW:0]   fifo_count;

  logic               load, sent, dropped;

  // Held packet plus every queued entry, saturating at 16'hFFFF.
  function automatic logic [15:0] drop_sat_add(input logic [15:0]    cnt,
                                               input logic [FIFO_AW:0] queued);
    logic [16:0] sum;
    sum = {1'b0, cnt} + 17'(queued) + 17'd1;
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Reset is folded in so the command port is closed while reset is held.
  assign bus.cmd_ready = user_aresetn & channel_up & ~fifo_full;
  assign fifo_push     = bus.cmd_valid & bus.cmd_ready;

  always_comb begin
    cmd_pkt      = '0;
    cmd_pkt.op   = bus.cmd_op;
    cmd_pkt.sync = bus.cmd_sync;
    cmd_pkt.seq  = seq;
    cmd_pkt.dst  = bus.cmd_dst;
    cmd_pkt.src  = {1'b0, ID};
    cmd_pkt.dt   = bus.cmd_dt;
  end

  tnet_sync_fifo #(
    .W  (128),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (user_clock),
    .rst_n (user_aresetn),
    .push  (fifo_push),
    .din   (cmd_pkt),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt  = state;
    tvalid_nxt = tvalid;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    load       = 1'b0;
    sent       = 1'b0;
    dropped    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (channel_up && !fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          if (fifo_head[SYNC_B]) begin
            state_nxt = ST_WAIT_SYNC;
          end else begin
            state_nxt  = ST_SEND;
            tvalid_nxt = 1'b1;
          end
        end
      end
      ST_WAIT_SYNC: begin
        if (!channel_up) begin
          dropped    = 1'b1;
          fifo_flush = 1'b1;
          tvalid_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end else if (sync_tick) begin
          state_nxt  = ST_SEND;
          tvalid_nxt = 1'b1;
        end
      end
      ST_SEND: begin
        // Link loss wins over a same-cycle handshake.
        if (!channel_up) begin
          dropped    = 1'b1;
          fifo_flush = 1'b1;
          tvalid_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end else if (bus.m_axi_tx_tready) begin
          sent       = 1'b1;
          tvalid_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        tvalid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge user_clock or negedge user_aresetn) begin
    if (!user_aresetn) begin
      state  <= ST_IDLE;
      tvalid <= 1'b0;
    end else begin
      state  <= state_nxt;
      tvalid <= tvalid_nxt;
    end
  end

  always_ff @(posedge user_clock or negedge user_aresetn) begin
    if (!user_aresetn) begin
      tdata    <= '0;
      seq      <= '0;
      tx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (load)
        tdata <= fifo_head;
      if (fifo_push)
        seq <= seq + 5'd1;
      if (sent)
        tx_cnt <= tx_cnt + 32'd1;
      if (dropped)
        drop_cnt <= drop_sat_add(drop_cnt, fifo_count);
    end
  end

  assign bus.m_axi_tx_tdata  = tdata;
  assign bus.m_axi_tx_tvalid = tvalid;
  assign busy = (state != ST_IDLE) | ~fifo_empty;

endmodule
